// File: rtl/matrix_pkg.sv
// Shared constants, FSM state types and address helpers for the matrix storage block.
// Also holds the slot and opcode constants used by matrix_alu.
package matrix_pkg;

  localparam int DW      = 16;
  localparam int MAX_DIM = 5;
  localparam int SLOTS   = 4;
  localparam int DEPTH   = SLOTS * MAX_DIM * MAX_DIM;
  localparam int AW      = $clog2(DEPTH);

  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_SCALE = 3'd3;
  localparam logic [2:0] OP_TRANS = 3'd4;

  typedef enum logic {L_IDLE = 1'b0, L_RUN = 1'b1} ld_state_e;
  typedef enum logic {D_IDLE = 1'b0, D_RUN = 1'b1} dp_state_e;

  function automatic logic [AW-1:0] elem_addr(input logic [1:0] slot,
                                               input logic [2:0] row,
                                               input logic [2:0] col);
    return AW'(slot) * AW'(MAX_DIM * MAX_DIM) + AW'(row) * AW'(MAX_DIM) + AW'(col);
  endfunction

  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && (n != 3'd0) && (m <= DIM_MAX) && (n <= DIM_MAX);
  endfunction

endpackage

// File: rtl/matrix_rowmajor_cnt.sv
// Row-major (row, col) walker over an m x n matrix; dims are captured on load
// so later dimension writes cannot disturb a transfer already in progress.
module matrix_rowmajor_cnt
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] m,
  input  logic [2:0] n,
  input  logic       adv,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] row_r, col_r, m_r, n_r;
  logic       row_end_s, col_end_s;

  assign col_end_s = (col_r == n_r - 3'd1);
  assign row_end_s = (row_r == m_r - 3'd1);

  // Counter state: clear on load, step column-first on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= 3'd0;
      col_r <= 3'd0;
      m_r   <= 3'd0;
      n_r   <= 3'd0;
    end else if (load) begin
      row_r <= 3'd0;
      col_r <= 3'd0;
      m_r   <= m;
      n_r   <= n;
    end else if (adv) begin
      if (col_end_s) begin
        col_r <= 3'd0;
        row_r <= row_end_s ? 3'd0 : row_r + 3'd1;
      end else begin
        col_r <= col_r + 3'd1;
      end
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign last = row_end_s && col_end_s;

endmodule

// File: rtl/matrix_mem.sv
// Slot-organised matrix store with ALU port, host stream loader and display streamer.
// Optional MEM_BOUNDS_CHECK_EN: masks out-of-dims reads, drops bad writes, pulses oob_err.
module matrix_mem
  import matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rd_slot,
  input  logic [2:0]    rd_row,
  input  logic [2:0]    rd_col,
  output logic [DW-1:0] rd_data,
  output logic [2:0]    rd_m,
  output logic [2:0]    rd_n,
  input  logic [1:0]    wr_slot,
  input  logic [2:0]    wr_row,
  input  logic [2:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_we,
  input  logic [2:0]    res_m,
  input  logic [2:0]    res_n,
  input  logic          dim_we,
  input  logic          ld_start,
  input  logic [1:0]    ld_slot,
  input  logic [2:0]    ld_m,
  input  logic [2:0]    ld_n,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_err,
  input  logic          dp_start,
  input  logic [1:0]    dp_slot,
  output logic [DW-1:0] dp_data,
  output logic [2:0]    dp_row,
  output logic [2:0]    dp_col,
  output logic          dp_valid,
  input  logic          dp_ready,
  output logic          dp_last,
  output logic          dp_empty,
  output logic          oob_err
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [2:0]    m_r   [SLOTS];
  logic [2:0]    n_r   [SLOTS];

  ld_state_e  ld_state_r, ld_state_nx_s;
  dp_state_e  dp_state_r, dp_state_nx_s;
  logic [1:0] ld_slot_r, dp_slot_r;
  logic       ld_load_s, ld_dim_we_s, ld_beat_s, ld_err_nx_s, ld_done_nx_s;
  logic       dp_load_s, dp_beat_s, dp_empty_nx_s;
  logic       ld_done_r, ld_err_r, dp_empty_r, oob_err_r;
  logic [2:0] ld_row_s, ld_col_s, dp_row_s, dp_col_s;
  logic       ld_last_s, dp_last_s;
  logic       elem_wr_s, dim_wr_s, oob_nx_s;

`ifdef MEM_BOUNDS_CHECK_EN
  assign elem_wr_s = wr_we && (wr_row < DIM_MAX) && (wr_col < DIM_MAX);
  assign dim_wr_s  = dim_we && (res_m <= DIM_MAX) && (res_n <= DIM_MAX);
  assign oob_nx_s  = (wr_we && !elem_wr_s) || (dim_we && !dim_wr_s);
`else
  assign elem_wr_s = wr_we;
  assign dim_wr_s  = dim_we;
  assign oob_nx_s  = 1'b0;
`endif

  // ALU read port, optionally masked to the slot's live dimensions.
  always_comb begin
    rd_data = mem_r[elem_addr(rd_slot, rd_row, rd_col)];
`ifdef MEM_BOUNDS_CHECK_EN
    if ((rd_row >= m_r[rd_slot]) || (rd_col >= n_r[rd_slot])) begin
      rd_data = {DW{1'b0}};
    end else begin
      rd_data = mem_r[elem_addr(rd_slot, rd_row, rd_col)];
    end
`endif
  end

  assign rd_m = m_r[rd_slot];
  assign rd_n = n_r[rd_slot];

  matrix_rowmajor_cnt u_ld_cnt (
    .clk (clk), .rst (rst), .load (ld_load_s), .m (ld_m), .n (ld_n),
    .adv (ld_beat_s), .row (ld_row_s), .col (ld_col_s), .last (ld_last_s)
  );

  matrix_rowmajor_cnt u_dp_cnt (
    .clk (clk), .rst (rst), .load (dp_load_s), .m (m_r[dp_slot]), .n (n_r[dp_slot]),
    .adv (dp_beat_s), .row (dp_row_s), .col (dp_col_s), .last (dp_last_s)
  );

  // Loader next state; ALU element writes steal the write port from the stream.
  always_comb begin
    ld_state_nx_s = ld_state_r;
    ld_load_s     = 1'b0;
    ld_dim_we_s   = 1'b0;
    ld_beat_s     = 1'b0;
    ld_err_nx_s   = 1'b0;
    ld_done_nx_s  = 1'b0;
    case (ld_state_r)
      L_IDLE: begin
        if (ld_start) begin
          if (dims_ok(ld_m, ld_n)) begin
            ld_load_s     = 1'b1;
            ld_dim_we_s   = 1'b1;
            ld_state_nx_s = L_RUN;
          end else begin
            ld_err_nx_s   = 1'b1;
          end
        end else begin
          ld_state_nx_s = L_IDLE;
        end
      end
      L_RUN: begin
        ld_beat_s = ld_valid && !wr_we;
        if (ld_beat_s && ld_last_s) begin
          ld_state_nx_s = L_IDLE;
          ld_done_nx_s  = 1'b1;
        end else begin
          ld_state_nx_s = L_RUN;
        end
      end
      default: ld_state_nx_s = L_IDLE;
    endcase
  end

  // Display next state; dims are sampled from the slot registers at start.
  always_comb begin
    dp_state_nx_s = dp_state_r;
    dp_load_s     = 1'b0;
    dp_beat_s     = 1'b0;
    dp_empty_nx_s = 1'b0;
    case (dp_state_r)
      D_IDLE: begin
        if (dp_start) begin
          if ((m_r[dp_slot] == 3'd0) || (n_r[dp_slot] == 3'd0)) begin
            dp_empty_nx_s = 1'b1;
          end else begin
            dp_load_s     = 1'b1;
            dp_state_nx_s = D_RUN;
          end
        end else begin
          dp_state_nx_s = D_IDLE;
        end
      end
      D_RUN: begin
        dp_beat_s = dp_ready;
        if (dp_beat_s && dp_last_s) begin
          dp_state_nx_s = D_IDLE;
        end else begin
          dp_state_nx_s = D_RUN;
        end
      end
      default: dp_state_nx_s = D_IDLE;
    endcase
  end

  // FSM state, captured slots and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_r <= L_IDLE;
      dp_state_r <= D_IDLE;
      ld_slot_r  <= 2'd0;
      dp_slot_r  <= 2'd0;
      ld_done_r  <= 1'b0;
      ld_err_r   <= 1'b0;
      dp_empty_r <= 1'b0;
      oob_err_r  <= 1'b0;
    end else begin
      ld_state_r <= ld_state_nx_s;
      dp_state_r <= dp_state_nx_s;
      ld_slot_r  <= ld_load_s ? ld_slot : ld_slot_r;
      dp_slot_r  <= dp_load_s ? dp_slot : dp_slot_r;
      ld_done_r  <= ld_done_nx_s;
      ld_err_r   <= ld_err_nx_s;
      dp_empty_r <= dp_empty_nx_s;
      oob_err_r  <= oob_nx_s;
    end
  end

  // Dimension registers; an ALU dim write beats a loader dim write to the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) begin
        m_r[s] <= 3'd0;
        n_r[s] <= 3'd0;
      end
    end else begin
      if (ld_dim_we_s && !(dim_wr_s && (wr_slot == ld_slot))) begin
        m_r[ld_slot] <= ld_m;
        n_r[ld_slot] <= ld_n;
      end
      if (dim_wr_s) begin
        m_r[wr_slot] <= res_m;
        n_r[wr_slot] <= res_n;
      end
    end
  end

  // Element storage; loader beats never coincide with an ALU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (elem_wr_s) begin
      mem_r[elem_addr(wr_slot, wr_row, wr_col)] <= wr_data;
    end else if (ld_beat_s) begin
      mem_r[elem_addr(ld_slot_r, ld_row_s, ld_col_s)] <= ld_data;
    end
  end

  assign ld_ready = (ld_state_r == L_RUN) && !wr_we;
  assign ld_done  = ld_done_r;
  assign ld_err   = ld_err_r;
  assign dp_valid = (dp_state_r == D_RUN);
  assign dp_data  = mem_r[elem_addr(dp_slot_r, dp_row_s, dp_col_s)];
  assign dp_row   = dp_row_s;
  assign dp_col   = dp_col_s;
  assign dp_last  = dp_valid && dp_last_s;
  assign dp_empty = dp_empty_r;
  assign oob_err  = oob_err_r;

endmodule

// File: tb/tb_matrix_mem.sv
// Scoreboard bench for matrix_mem: loads, ALU port, dumps, dim collisions, reset, bounds option.
module tb_matrix_mem;
  import matrix_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rd_slot, wr_slot, ld_slot, dp_slot;
  logic [2:0]    rd_row, rd_col, wr_row, wr_col, res_m, res_n, ld_m, ld_n;
  logic [DW-1:0] rd_data, wr_data, ld_data, dp_data;
  logic [2:0]    rd_m, rd_n, dp_row, dp_col;
  logic          wr_we, dim_we, ld_start, ld_valid, ld_ready, ld_done, ld_err;
  logic          dp_start, dp_valid, dp_ready, dp_last, dp_empty, oob_err;

  matrix_mem dut (
    .clk(clk), .rst(rst),
    .rd_slot(rd_slot), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_m(rd_m), .rd_n(rd_n),
    .wr_slot(wr_slot), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_we(wr_we),
    .res_m(res_m), .res_n(res_n), .dim_we(dim_we),
    .ld_start(ld_start), .ld_slot(ld_slot), .ld_m(ld_m), .ld_n(ld_n), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
    .dp_start(dp_start), .dp_slot(dp_slot), .dp_data(dp_data), .dp_row(dp_row), .dp_col(dp_col),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_last(dp_last), .dp_empty(dp_empty), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    row;
    logic [2:0]    col;
    logic [DW-1:0] data;
    logic          last;
  } dp_exp_t;

  dp_exp_t       sb_q[$];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [2:0]    exp_m [SLOTS];
  logic [2:0]    exp_n [SLOTS];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int s, input int r, input int c);
`ifdef MEM_BOUNDS_CHECK_EN
    if (r >= int'(exp_m[s]) || c >= int'(exp_n[s])) return {DW{1'b0}};
`endif
    return exp_mem[s*MAX_DIM*MAX_DIM + r*MAX_DIM + c];
  endfunction

  task automatic rd_chk(input string tag, input int s, input int r, input int c);
    rd_slot = 2'(s); rd_row = 3'(r); rd_col = 3'(c);
    #1;
    check_eq(tag, 32'(rd_data), 32'(exp_rd(s, r, c)));
  endtask

  task automatic dims_chk(input string tag, input int s);
    rd_slot = 2'(s);
    #1;
    check_eq({tag, "_m"}, 32'(rd_m), 32'(exp_m[s]));
    check_eq({tag, "_n"}, 32'(rd_n), 32'(exp_n[s]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = {DW{1'b0}};
    for (int s = 0; s < SLOTS; s++) begin exp_m[s] = 3'd0; exp_n[s] = 3'd0; end
  endtask

  // Starts a load whose dims are legal; the model mirrors the slot dims.
  task automatic start_load(input int s, input int m, input int n);
    ld_start = 1'b1; ld_slot = 2'(s); ld_m = 3'(m); ld_n = 3'(n);
    step();
    ld_start = 1'b0;
  endtask

  // Streams m*n beats with ld_valid held high, checking ld_ready each cycle.
  task automatic stream(input int s, input int m, input int n, input int base);
    for (int k = 0; k < m*n; k++) begin
      ld_valid = 1'b1; ld_data = DW'(base + k);
      #1;
      check_eq("ld_ready_beat", 32'(ld_ready), 32'd1);
      step();
      exp_mem[s*25 + (k/n)*5 + (k%n)] = DW'(base + k);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_slot = 2'd0; rd_row = 3'd0; rd_col = 3'd0;
    wr_slot = 2'd0; wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'h0000; wr_we = 1'b0;
    res_m = 3'd0; res_n = 3'd0; dim_we = 1'b0;
    ld_start = 1'b0; ld_slot = 2'd0; ld_m = 3'd0; ld_n = 3'd0; ld_data = 16'h0000; ld_valid = 1'b0;
    dp_start = 1'b0; dp_slot = 2'd0; dp_ready = 1'b0;
    model_reset();
    step(); step();

    check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_ld_done",  32'(ld_done),  32'd0);
    check_eq("rst_ld_err",   32'(ld_err),   32'd0);
    check_eq("rst_dp_valid", 32'(dp_valid), 32'd0);
    check_eq("rst_dp_empty", 32'(dp_empty), 32'd0);
    check_eq("rst_oob_err",  32'(oob_err),  32'd0);
    rd_chk("rst_rd_data", 0, 0, 0);
    dims_chk("rst_dims", 0);
    rst = 1'b0;
    step();

    // Load A 2x3 with 1..6.
    start_load(0, 2, 3);
    exp_m[0] = 3'd2; exp_n[0] = 3'd3;
    stream(0, 2, 3, 1);
    check_eq("ld_done_pulse", 32'(ld_done), 32'd1);
    check_eq("ld_ready_after", 32'(ld_ready), 32'd0);
    rd_chk("rd_A12", 0, 1, 2);
    rd_chk("rd_A00", 0, 0, 0);
    dims_chk("dims_A", 0);
    step();
    check_eq("ld_done_once", 32'(ld_done), 32'd0);

    // Rejected starts: m=0 then m=6.
    ld_start = 1'b1; ld_slot = 2'd1; ld_m = 3'd0; ld_n = 3'd3;
    step();
    check_eq("ld_err_m0", 32'(ld_err), 32'd1);
    check_eq("ld_ready_m0", 32'(ld_ready), 32'd0);
    ld_m = 3'd6;
    step();
    ld_start = 1'b0;
    check_eq("ld_err_m6", 32'(ld_err), 32'd1);
    check_eq("ld_ready_m6", 32'(ld_ready), 32'd0);
    dims_chk("dims_B_unchanged", 1);
    step();
    check_eq("ld_err_clear", 32'(ld_err), 32'd0);

    // ALU writes stall the loader for two cycles.
    start_load(1, 1, 2);
    exp_m[1] = 3'd1; exp_n[1] = 3'd2;
    wr_we = 1'b1; wr_slot = 2'd2; wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'h7FFF;
    ld_valid = 1'b1; ld_data = 16'h0011;
    rd_slot = 2'd2; rd_row = 3'd0; rd_col = 3'd0;
    #1;
    check_eq("ld_ready_stall1", 32'(ld_ready), 32'd0);
    check_eq("rd_old_same_cycle", 32'(rd_data), 32'(exp_rd(2, 0, 0)));
    step();
    exp_mem[50] = 16'h7FFF;
    wr_col = 3'd1; wr_data = 16'h1234;
    #1;
    check_eq("ld_ready_stall2", 32'(ld_ready), 32'd0);
    check_eq("rd_C00_next", 32'(rd_data), 32'(exp_rd(2, 0, 0)));
    step();
    exp_mem[51] = 16'h1234;
    wr_we = 1'b0;
    stream(1, 1, 2, 16'h0011);
    check_eq("ld_done_stall", 32'(ld_done), 32'd1);
    rd_chk("rd_B00", 1, 0, 0);
    rd_chk("rd_B01", 1, 0, 1);
    rd_chk("rd_C01", 2, 0, 1);

    // Dump A with dp_ready toggling; expectations queued at start.
    for (int r = 0; r < int'(exp_m[0]); r++)
      for (int c = 0; c < int'(exp_n[0]); c++)
        sb_q.push_back({3'(r), 3'(c), exp_mem[r*5 + c],
                        (r == int'(exp_m[0]) - 1) && (c == int'(exp_n[0]) - 1)});
    dp_start = 1'b1; dp_slot = 2'd0;
    #1;
    check_eq("dp_valid_idle", 32'(dp_valid), 32'd0);
    step();
    dp_start = 1'b0;
    begin
      int  cyc = 0;
      bit  tog = 1'b1;
      dp_exp_t e;
      while (sb_q.size() > 0 && cyc < 40) begin
        dp_ready = tog;
        #1;
        if (dp_valid) begin
          e = sb_q[0];
          check_eq("dp_row",  32'(dp_row),  32'(e.row));
          check_eq("dp_col",  32'(dp_col),  32'(e.col));
          check_eq("dp_data", 32'(dp_data), 32'(e.data));
          check_eq("dp_last", 32'(dp_last), 32'(e.last));
          if (dp_ready) void'(sb_q.pop_front());
        end else begin
          check_eq("dp_valid_gap", 32'(dp_valid), 32'd1);
        end
        step();
        tog = ~tog;
        cyc++;
      end
    end
    check_eq("dump_drained", 32'(sb_q.size()), 32'd0);
    dp_ready = 1'b0;
    #1;
    check_eq("dp_valid_after", 32'(dp_valid), 32'd0);

    // Empty slot D.
    dp_start = 1'b1; dp_slot = 2'd3;
    step();
    dp_start = 1'b0;
    check_eq("dp_empty_pulse", 32'(dp_empty), 32'd1);
    check_eq("dp_valid_empty", 32'(dp_valid), 32'd0);
    step();
    check_eq("dp_empty_once", 32'(dp_empty), 32'd0);
    check_eq("dp_valid_empty2", 32'(dp_valid), 32'd0);

    // ALU dim write and loader start on slot C in the same cycle.
    dim_we = 1'b1; wr_slot = 2'd2; res_m = 3'd3; res_n = 3'd3;
    start_load(2, 2, 2);
    dim_we = 1'b0;
    exp_m[2] = 3'd3; exp_n[2] = 3'd3;
    dims_chk("dims_C_collide", 2);
    stream(2, 2, 2, 16'h0100);
    check_eq("ld_done_C", 32'(ld_done), 32'd1);
    rd_chk("rd_C11", 2, 1, 1);

    // Different slots in the same cycle, then reset in the middle of the load.
    dim_we = 1'b1; wr_slot = 2'd3; res_m = 3'd1; res_n = 3'd1;
    start_load(1, 3, 3);
    dim_we = 1'b0;
    exp_m[3] = 3'd1; exp_n[3] = 3'd1; exp_m[1] = 3'd3; exp_n[1] = 3'd3;
    dims_chk("dims_D_split", 3);
    dims_chk("dims_B_split", 1);
    ld_valid = 1'b1; ld_data = 16'h0200;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_eq("rst_mid_ready", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_mid_no_done", 32'(ld_done), 32'd0);
      check_eq("rst_mid_ready_hold", 32'(ld_ready), 32'd0);
    end
    ld_valid = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      dims_chk("rst_mid_dims", s);
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          rd_chk("rst_mid_rd", s, r, c);
    end

`ifdef MEM_BOUNDS_CHECK_EN
    dim_we = 1'b1; wr_slot = 2'd0; res_m = 3'd5; res_n = 3'd5;
    step();
    wr_slot = 2'd1;
    step();
    dim_we = 1'b0;
    exp_m[0] = 3'd5; exp_n[0] = 3'd5; exp_m[1] = 3'd5; exp_n[1] = 3'd5;
    wr_we = 1'b1; wr_slot = 2'd0; wr_row = 3'd5; wr_col = 3'd0; wr_data = 16'hBEEF;
    step();
    wr_we = 1'b0;
    check_eq("oob_wr_pulse", 32'(oob_err), 32'd1);
    step();
    check_eq("oob_wr_once", 32'(oob_err), 32'd0);
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          rd_chk("oob_unchanged", s, r, c);
    dim_we = 1'b1; wr_slot = 2'd0; res_m = 3'd6; res_n = 3'd2;
    step();
    dim_we = 1'b0;
    check_eq("oob_dim_pulse", 32'(oob_err), 32'd1);
    dims_chk("oob_dims_kept", 0);
    wr_we = 1'b1; wr_slot = 2'd0; wr_row = 3'd4; wr_col = 3'd4; wr_data = 16'h0055;
    step();
    wr_we = 1'b0;
    exp_mem[24] = 16'h0055;
    rd_chk("mask_in_dims", 0, 4, 4);
    dim_we = 1'b1; wr_slot = 2'd0; res_m = 3'd2; res_n = 3'd2;
    step();
    dim_we = 1'b0;
    exp_m[0] = 3'd2; exp_n[0] = 3'd2;
    rd_chk("mask_out_dims", 0, 4, 4);
`else
    wr_we = 1'b1; wr_slot = 2'd0; wr_row = 3'd4; wr_col = 3'd4; wr_data = 16'h0055;
    step();
    wr_we = 1'b0;
    exp_mem[24] = 16'h0055;
    check_eq("oob_tied_low", 32'(oob_err), 32'd0);
    rd_chk("rd_A44_nodims", 0, 4, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mem.md
Name: matrix_mem

Overview:
- Slot-organised matrix storage; the responder for the matrix ALU's memory interface.
- Serves combinational element/dimension reads, and element/dimension writes from the ALU.
- Adds a host streaming loader (user matrix entry) and a display streamer (row-major dump to the UI).
- Sits between matrix_alu, the input parser and the display controller.

Parameters:
- DW, 16, element width (two's complement)
- MAX_DIM, 5, maximum rows/cols per matrix
- SLOTS, 4, number of matrix slots (A=0, B=1, C=2, D=3)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rd_slot  in  2  ALU read slot
- rd_row  in  3  ALU read row
- rd_col  in  3  ALU read column
- rd_data  out  DW  element at rd_slot/row/col (combinational)
- rd_m  out  3  row count of rd_slot (combinational)
- rd_n  out  3  column count of rd_slot (combinational)
- wr_slot  in  2  ALU write slot
- wr_row  in  3  ALU write row
- wr_col  in  3  ALU write column
- wr_data  in  DW  ALU write data
- wr_we  in  1  ALU element write strobe
- res_m  in  3  ALU result row count
- res_n  in  3  ALU result column count
- dim_we  in  1  ALU dimension write strobe (targets wr_slot)
- ld_start  in  1  begin a load
- ld_slot  in  2  load target slot
- ld_m  in  3  load row count
- ld_n  in  3  load column count
- ld_data  in  DW  element stream
- ld_valid  in  1  element valid
- ld_ready  out  1  loader accepts element
- ld_done  out  1  1-cycle pulse, load complete
- ld_err  out  1  1-cycle pulse, load start rejected
- dp_start  in  1  begin a dump
- dp_slot  in  2  dump slot
- dp_data  out  DW  element being presented
- dp_row  out  3  row of presented element
- dp_col  out  3  column of presented element
- dp_valid  out  1  presented element valid
- dp_ready  in  1  sink accepts element
- dp_last  out  1  presented element is last
- dp_empty  out  1  1-cycle pulse, slot has zero dimensions
- oob_err  out  1  1-cycle pulse, bounds violation (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset effects: all elements and all dims cleared to 0; both FSMs go IDLE; every registered output 0. Reset mid-load or mid-dump aborts it, with no done/last pulse.
- Storage: flat array indexed slot*MAX_DIM*MAX_DIM + row*MAX_DIM + col, plus per-slot m/n registers.
- Reads: rd_data, rd_m and rd_n are combinational, zero latency. A write takes effect at the clock edge, so a same-cycle read returns the old value.
- ALU writes: wr_we writes the element; dim_we writes res_m/res_n into wr_slot. Both take effect next edge.
- Loader FSM, L_IDLE -> L_RUN -> L_IDLE:
  - ld_start in IDLE: if ld_m or ld_n is 0 or >MAX_DIM, pulse ld_err and stay IDLE.
  - Otherwise write dims of ld_slot, clear row/col counters, go to RUN.
  - ld_ready = RUN && !wr_we; ALU element writes have priority.
  - A beat (ld_valid && ld_ready) writes (r,c) and advances row-major.
  - The beat at (m-1,n-1) returns to IDLE; ld_done pulses the cycle after.
  - ld_start in RUN is ignored.
- Display FSM, D_IDLE -> D_RUN -> D_IDLE:
  - dp_start in IDLE snapshots slot and dims; zero dims pulse dp_empty and stay IDLE.
  - In RUN: dp_valid=1; dp_data/dp_row/dp_col reflect the current counter, with dp_data read combinationally (it tracks concurrent writes).
  - dp_last = (r==m-1 && c==n-1).
  - A beat (dp_valid && dp_ready) advances; the last beat returns to IDLE. dp_start in RUN is ignored.
- Simultaneous events:
  - dim_we and loader dim write in the same cycle to the same slot: dim_we wins. Different slots: both are written.
  - Loader and display may run concurrently.

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - rd_data returns 0 when rd_row>=rd_m or rd_col>=rd_n of rd_slot.
  - wr_we with wr_row or wr_col >= MAX_DIM is dropped and pulses oob_err next cycle.
  - dim_we with res_m or res_n >MAX_DIM is dropped and pulses oob_err.
- Undefined:
  - No masking and no checks; oob_err is tied 0.
  - Callers must keep indices below MAX_DIM.

Decomposition:
- Package matrix_pkg: DW, MAX_DIM, SLOTS, slot constants SLOT_A..SLOT_D, ALU opcode constants (shared with matrix_alu).
- One sub-module, matrix_rowmajor_cnt: row/col counter with load, advance and last-flag outputs. It is instantiated twice, by the loader and the display.

Test Plan:
- Load slot A 2x3 with 1..6, ld_valid held high → ld_ready for 6 cycles, ld_done one cycle after the 6th beat; rd_slot=0, rd_row=1, rd_col=2 gives rd_data=6, rd_m=2, rd_n=3.
- ld_start with ld_m=0, then with ld_m=6 → ld_err pulse each time, slot dims unchanged, ld_ready stays 0.
- Loader in RUN with wr_we=1 for 2 cycles → ld_ready=0 in those cycles, no element lost; the ALU write to C[0][0]=0x7FFF reads back next cycle.
- Dump slot A (2x3) with dp_ready toggling 1,0,1,... → 6 beats in order (0,0)..(1,2) with data 1..6, dp_last only on (1,2); dump of an empty slot D → dp_empty pulse, dp_valid never high.
- dim_we (res 3x3, slot C) in the same cycle as ld_start for slot C (2x2) → dims of C = 3x3.
- Reset asserted mid-load → ld_ready=0 and no ld_done; all rd_data=0; with MEM_BOUNDS_CHECK_EN, write to row 5 → oob_err pulse and the storage is unchanged.
